// File: rtl/dcache_wb_pkg.sv
// Shared types and helpers for the direct-mapped write-back data cache.
package dcache_wb_pkg;

    localparam int DC_WORD_BYTES = 4;

    typedef enum logic [1:0] {
        DC_IDLE,
        DC_WRITEBACK,
        DC_REFILL
    } dcache_state_e;

    // Byte-lane merge used by store hits.
    function automatic logic [31:0] dc_merge_word(
        input logic [31:0]              old_word,
        input logic [31:0]              new_word,
        input logic [DC_WORD_BYTES-1:0] be
    );
        logic [31:0] merged;
        merged = old_word;
        for (int k = 0; k < DC_WORD_BYTES; k++) begin
            if (be[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dcache_wb_line_store.sv
// Tag/valid/dirty/data arrays for the cache; valid and dirty clear on reset,
// tags and data do not.
module dcache_wb_line_store
    import dcache_wb_pkg::*;
#(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 4,
    parameter int TAG_ADDR_LEN  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [SET_ADDR_LEN-1:0]        set_i,
    input  logic [LINE_ADDR_LEN-1:0]       word_i,
    input  logic                           word_we_i,
    input  logic [DC_WORD_BYTES-1:0]       word_be_i,
    input  logic [31:0]                    word_wdata_i,
    input  logic                           line_we_i,
    input  logic [TAG_ADDR_LEN-1:0]        line_tag_i,
    input  logic [(32<<LINE_ADDR_LEN)-1:0] line_wdata_i,
    output logic                           valid_o,
    output logic                           dirty_o,
    output logic [TAG_ADDR_LEN-1:0]        tag_o,
    output logic [(32<<LINE_ADDR_LEN)-1:0] line_o,
    output logic [31:0]                    word_o
);

    localparam int SETS = 1 << SET_ADDR_LEN;
    localparam int LW   = 32 << LINE_ADDR_LEN;

    logic [SETS-1:0]         valid_q, valid_d;
    logic [SETS-1:0]         dirty_q, dirty_d;
    logic [TAG_ADDR_LEN-1:0] tag_mem  [SETS];
    logic [LW-1:0]           data_mem [SETS];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (line_we_i) begin
            valid_d[set_i] = 1'b1;
            dirty_d[set_i] = 1'b0;
        end else if (word_we_i) begin
            dirty_d[set_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Arrays are plain RAM; a full-line refill takes priority over a word store.
    always_ff @(posedge clk) begin
        if (line_we_i) begin
            tag_mem[set_i]  <= line_tag_i;
            data_mem[set_i] <= line_wdata_i;
        end else if (word_we_i) begin
            data_mem[set_i][{word_i, 5'd0} +: 32] <=
                dc_merge_word(data_mem[set_i][{word_i, 5'd0} +: 32], word_wdata_i, word_be_i);
        end
    end

    assign valid_o = valid_q[set_i];
    assign dirty_o = dirty_q[set_i];
    assign tag_o   = tag_mem[set_i];
    assign line_o  = data_mem[set_i];
    assign word_o  = line_o[{word_i, 5'd0} +: 32];

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate data cache: miss FSM, hit path
// and access counters around dcache_wb_line_store.
module dcache_wb
    import dcache_wb_pkg::*;
#(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 4,
    parameter int TAG_ADDR_LEN  = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 req_i,
    input  logic                                 we_i,
    input  logic [3:0]                           be_i,
    input  logic [31:0]                          addr_i,
    input  logic [31:0]                          wdata_i,
    output logic [31:0]                          rdata_o,
    output logic                                 miss_o,
    output logic                                 mem_req_o,
    output logic                                 mem_we_o,
    output logic [TAG_ADDR_LEN+SET_ADDR_LEN-1:0] mem_addr_o,
    output logic [(32<<LINE_ADDR_LEN)-1:0]       mem_wline_o,
    input  logic [(32<<LINE_ADDR_LEN)-1:0]       mem_rline_i,
    input  logic                                 mem_gnt_i,
    output logic [31:0]                          hit_cnt_o,
    output logic [31:0]                          miss_cnt_o
);

    localparam int LW      = 32 << LINE_ADDR_LEN;
    localparam int TAG_LSB = LINE_ADDR_LEN + SET_ADDR_LEN + 2;

    logic [LINE_ADDR_LEN-1:0] word;
    logic [SET_ADDR_LEN-1:0]  set;
    logic [TAG_ADDR_LEN-1:0]  tag;
    logic                     unused_addr;

    assign word        = addr_i[LINE_ADDR_LEN+1:2];
    assign set         = addr_i[LINE_ADDR_LEN+2 +: SET_ADDR_LEN];
    assign tag         = addr_i[TAG_LSB +: TAG_ADDR_LEN];
    assign unused_addr = ^{addr_i[31:TAG_LSB+TAG_ADDR_LEN], addr_i[1:0]};

    dcache_state_e state_q, state_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   hit_cnt_q, hit_cnt_d;
    logic [31:0]   miss_cnt_q, miss_cnt_d;

    logic                    line_valid, line_dirty, hit;
    logic [TAG_ADDR_LEN-1:0] line_tag;
    logic [LW-1:0]           line_rd;
    logic [31:0]             word_rd;
    logic                    word_we, line_we;

    dcache_wb_line_store #(
        .LINE_ADDR_LEN (LINE_ADDR_LEN),
        .SET_ADDR_LEN  (SET_ADDR_LEN),
        .TAG_ADDR_LEN  (TAG_ADDR_LEN)
    ) u_store (
        .clk          (clk),
        .rst_n        (rst_n),
        .set_i        (set),
        .word_i       (word),
        .word_we_i    (word_we),
        .word_be_i    (be_i),
        .word_wdata_i (wdata_i),
        .line_we_i    (line_we),
        .line_tag_i   (tag),
        .line_wdata_i (mem_rline_i),
        .valid_o      (line_valid),
        .dirty_o      (line_dirty),
        .tag_o        (line_tag),
        .line_o       (line_rd),
        .word_o       (word_rd)
    );

    assign hit = line_valid & (line_tag == tag);

    // The core holds its request through a miss, so set/tag stay valid for the whole sequence.
    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        word_we    = 1'b0;
        line_we    = 1'b0;
        case (state_q)
            DC_IDLE: begin
                if (req_i) begin
                    if (hit) begin
                        hit_cnt_d = hit_cnt_q + 32'd1;
                        if (we_i) begin
                            word_we = 1'b1;
                        end else begin
                            rdata_d = word_rd;
                        end
                    end else begin
                        miss_cnt_d = miss_cnt_q + 32'd1;
                        state_d    = (line_valid && line_dirty) ? DC_WRITEBACK : DC_REFILL;
                    end
                end
            end
            DC_WRITEBACK: begin
                if (mem_gnt_i) begin
                    state_d = DC_REFILL;
                end
            end
            DC_REFILL: begin
                if (mem_gnt_i) begin
                    line_we = 1'b1;
                    state_d = DC_IDLE;
                end
            end
            default: state_d = DC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= DC_IDLE;
            rdata_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rdata_q    <= rdata_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign miss_o      = (state_q != DC_IDLE) | (req_i & ~hit);
    assign mem_req_o   = (state_q != DC_IDLE);
    assign mem_we_o    = (state_q == DC_WRITEBACK);
    assign mem_addr_o  = (state_q == DC_WRITEBACK) ? {line_tag, set} : {tag, set};
    assign mem_wline_o = line_rd;
    assign rdata_o     = rdata_q;
    assign hit_cnt_o   = hit_cnt_q;
    assign miss_cnt_o  = miss_cnt_q;

endmodule

// File: tb/tb_dcache_wb.sv
// Self-checking bench for dcache_wb: directed scenarios plus randomized
// accesses against an array-based cache/memory model with a random-latency responder.
module tb_dcache_wb;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_i, we_i;
    logic [3:0]   be_i;
    logic [31:0]  addr_i, wdata_i;
    logic [31:0]  rdata_o;
    logic         miss_o, mem_req_o, mem_we_o;
    logic [7:0]   mem_addr_o;
    logic [255:0] mem_wline_o, mem_rline_i;
    logic         mem_gnt_i;
    logic [31:0]  hit_cnt_o, miss_cnt_o;

    always #5 clk = ~clk;

    dcache_wb dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .we_i        (we_i),
        .be_i        (be_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .miss_o      (miss_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wline_o (mem_wline_o),
        .mem_rline_i (mem_rline_i),
        .mem_gnt_i   (mem_gnt_i),
        .hit_cnt_o   (hit_cnt_o),
        .miss_cnt_o  (miss_cnt_o)
    );

    typedef struct {
        bit         we;
        bit [7:0]   addr;
        bit [255:0] line;
    } tx_t;

    // Reference model: cache contents, backing memory, expected outputs
    bit [3:0]   m_tag   [16];
    bit         m_valid [16];
    bit         m_dirty [16];
    bit [255:0] m_line  [16];
    bit [255:0] mem_arr [256];
    bit [31:0]  exp_rdata, m_hit_cnt, m_miss_cnt;
    tx_t        exp_q[$];

    int         n_checks = 0;
    int         n_fail   = 0;
    bit         started  = 0;
    bit         resp_en  = 1;
    int         fixed_delay = -1;
    bit         log_we[$];
    bit [7:0]   log_addr[$];
    bit [255:0] log_wline[$];

    function automatic bit [3:0] set_of(input bit [31:0] a);
        return a[8:5];
    endfunction

    function automatic bit [3:0] tag_of(input bit [31:0] a);
        return a[12:9];
    endfunction

    function automatic bit model_hit(input bit [31:0] a);
        return m_valid[set_of(a)] && (m_tag[set_of(a)] == tag_of(a));
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 16; s++) begin
            m_valid[s] = 0;
            m_dirty[s] = 0;
        end
        exp_rdata  = 0;
        m_hit_cnt  = 0;
        m_miss_cnt = 0;
        exp_q.delete();
    endtask

    task automatic clear_log();
        log_we.delete();
        log_addr.delete();
        log_wline.delete();
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every core-facing output against the model
    always @(negedge clk) begin
        if (started) begin
            checkOutput("miss_o", miss_o, (req_i && !model_hit(addr_i)) ? 1 : 0);
            checkOutput("rdata_o", rdata_o, exp_rdata);
            checkOutput("hit_cnt_o", hit_cnt_o, m_hit_cnt);
            checkOutput("miss_cnt_o", miss_cnt_o, m_miss_cnt);
        end
    end

    // Memory responder: checks each transaction against the expected queue,
    // holds it for a random number of cycles, then pulses gnt
    initial begin : responder
        tx_t e;
        int  d;
        mem_gnt_i   = 0;
        mem_rline_i = '0;
        forever begin
            @(negedge clk);
            if (resp_en && rst_n && mem_req_o) begin
                log_we.push_back(mem_we_o);
                log_addr.push_back(mem_addr_o);
                log_wline.push_back(mem_wline_o);
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_mem_req", 1, 0);
                    e.we = mem_we_o; e.addr = mem_addr_o; e.line = mem_wline_o;
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("mem_we_o", mem_we_o, e.we);
                    checkOutput("mem_addr_o", mem_addr_o, e.addr);
                    if (e.we) begin
                        for (int k = 0; k < 8; k++)
                            checkOutput("mem_wline_o", mem_wline_o[32*k +: 32], e.line[32*k +: 32]);
                    end
                end
                d = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, 4);
                repeat (d) begin
                    @(negedge clk);
                    checkOutput("mem_req_hold", mem_req_o, 1);
                    checkOutput("mem_addr_hold", mem_addr_o, e.addr);
                end
                mem_rline_i = e.we ? {8{$urandom}} : mem_arr[e.addr];
                mem_gnt_i   = 1;
                @(posedge clk);
                #1;
                mem_gnt_i = 0;
                if (e.we) begin
                    mem_arr[e.addr] = e.line;
                end else begin
                    m_tag[e.addr[3:0]]   = e.addr[7:4];
                    m_valid[e.addr[3:0]] = 1;
                    m_dirty[e.addr[3:0]] = 0;
                    m_line[e.addr[3:0]]  = mem_arr[e.addr];
                end
            end
        end
    end

    // Issues one access at posedge+1, waits for completion and updates the model
    task automatic applyStimulus(input bit we, input bit [3:0] be, input bit [31:0] addr,
                                 input bit [31:0] wdata, output int stalls);
        bit [3:0] s;
        bit       done;
        int       w;
        tx_t      t;
        s = set_of(addr);
        w = int'(addr[4:2]);
        req_i = 1; we_i = we; be_i = be; addr_i = addr; wdata_i = wdata;
        stalls = 0;
        done   = 0;
        if (!model_hit(addr)) begin
            if (m_valid[s] && m_dirty[s]) begin
                t.we = 1; t.addr = {m_tag[s], s}; t.line = m_line[s];
                exp_q.push_back(t);
            end
            t.we = 0; t.addr = {tag_of(addr), s}; t.line = '0;
            exp_q.push_back(t);
        end
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (model_hit(addr)) begin
                done = 1;
            end else begin
                if (miss_o) stalls++;
                if (i == 0) begin
                    @(posedge clk);
                    m_miss_cnt++;
                end
            end
        end
        if (!done) begin
            checkOutput("access_timeout", 0, 1);
            req_i = 0;
            return;
        end
        @(posedge clk);
        m_hit_cnt++;
        if (we) begin
            for (int k = 0; k < 4; k++)
                if (be[k]) m_line[s][32*w + 8*k +: 8] = wdata[8*k +: 8];
            m_dirty[s] = 1;
        end else begin
            exp_rdata = m_line[s][32*w +: 32];
        end
        #1;
    endtask

    task automatic idle(input int n);
        req_i = 0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int       stalls;
        bit [31:0] a;
        rst_n = 0; req_i = 0; we_i = 0; be_i = 0; addr_i = 0; wdata_i = 0;
        for (int i = 0; i < 256; i++) mem_arr[i] = {8{$urandom}};
        mem_arr[8'h02][31:0] = 32'h1122_3344;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n   = 1;
        started = 1;
        @(negedge clk);
        checkOutput("reset_mem_req", mem_req_o, 0);
        checkOutput("reset_rdata", rdata_o, 32'h0);
        @(posedge clk);
        #1;

        // Cold read with a fixed 5-cycle memory latency
        fixed_delay = 4;
        clear_log();
        applyStimulus(0, 4'h0, 32'h0000_0040, 32'h0, stalls);
        checkOutput("t1_stalls", stalls, 6);
        checkOutput("t1_rdata", rdata_o, 32'h1122_3344);
        checkOutput("t1_miss_cnt", miss_cnt_o, 1);
        checkOutput("t1_hit_cnt", hit_cnt_o, 1);
        checkOutput("t1_tx_count", log_addr.size(), 1);
        checkOutput("t1_tx_addr", log_addr[0], 8'h02);
        checkOutput("t1_tx_we", log_we[0], 0);
        fixed_delay = -1;

        // Partial store then read-back, no memory traffic
        applyStimulus(1, 4'b0110, 32'h0000_0040, 32'hAABB_CCDD, stalls);
        applyStimulus(0, 4'h0, 32'h0000_0040, 32'h0, stalls);
        checkOutput("t2_rdata", rdata_o, 32'h11BB_CC44);
        checkOutput("t2_tx_count", log_addr.size(), 1);

        // Dirty conflict: writeback of tag 0 then refill of tag 1
        clear_log();
        applyStimulus(0, 4'h0, 32'h0000_0240, 32'h0, stalls);
        checkOutput("t3_tx_count", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            checkOutput("t3_wb_we", log_we[0], 1);
            checkOutput("t3_wb_addr", log_addr[0], 8'h02);
            checkOutput("t3_wb_word0", log_wline[0][31:0], 32'h11BB_CC44);
            checkOutput("t3_rf_we", log_we[1], 0);
            checkOutput("t3_rf_addr", log_addr[1], 8'h12);
        end

        // Clean conflict: refill only, written-back data comes home
        clear_log();
        applyStimulus(0, 4'h0, 32'h0000_0040, 32'h0, stalls);
        checkOutput("t4_tx_count", log_addr.size(), 1);
        checkOutput("t4_tx_we", log_we[0], 0);
        checkOutput("t4_rdata", rdata_o, 32'h11BB_CC44);

        // Back-to-back hits over a whole line
        for (int w = 0; w < 8; w++) begin
            applyStimulus(0, 4'h0, 32'h0000_0040 + 32'(4 * w), 32'h0, stalls);
            checkOutput("t5_no_stall", stalls, 0);
            if (w == 0) checkOutput("t5_word0", rdata_o, 32'h11BB_CC44);
        end
        checkOutput("t5_hit_cnt", hit_cnt_o, 13);
        checkOutput("t5_miss_cnt", miss_cnt_o, 3);

        // Reset in the middle of a refill, then a late stray gnt
        resp_en = 0;
        req_i = 1; we_i = 0; be_i = 0; addr_i = 32'h0000_0080;
        @(negedge clk);
        @(posedge clk);
        m_miss_cnt++;
        repeat (3) @(negedge clk);
        checkOutput("t6_mem_req", mem_req_o, 1);
        checkOutput("t6_mem_we", mem_we_o, 0);
        checkOutput("t6_mem_addr", mem_addr_o, 8'h04);
        @(posedge clk);
        #1;
        rst_n = 0;
        req_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        @(negedge clk);
        mem_rline_i = {8{$urandom}};
        mem_gnt_i   = 1;
        @(posedge clk);
        #1;
        mem_gnt_i = 0;
        @(negedge clk);
        checkOutput("t6_req_dropped", mem_req_o, 0);
        checkOutput("t6_idle", miss_o, 0);
        checkOutput("t6_miss_cnt0", miss_cnt_o, 0);
        checkOutput("t6_hit_cnt0", hit_cnt_o, 0);
        @(posedge clk);
        #1;
        resp_en = 1;
        clear_log();
        applyStimulus(0, 4'h0, 32'h0000_0080, 32'h0, stalls);
        checkOutput("t6_missed_again", (stalls > 0) ? 1 : 0, 1);
        checkOutput("t6_tx_count", log_addr.size(), 1);
        checkOutput("t6_miss_cnt", miss_cnt_o, 1);
        checkOutput("t6_hit_cnt", hit_cnt_o, 1);

        // Random traffic over a few sets and tags, with aliasing upper bits
        for (int n = 0; n < 400; n++) begin
            a = $urandom;
            a[12:9] = 4'($urandom_range(0, 3));
            a[8:5]  = 4'($urandom_range(0, 3));
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom), a, $urandom, stalls);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(4);
        checkOutput("exp_q_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
